// File: rtl/pc_addr_unit.sv
// Program counter and memory address stage.
// Holds the PC and the data-address register, evaluates branch conditions
// from the status flags, and picks the branch target. The target is either
// PC-relative or taken from a register. Drives the shared memory address bus
// and supplies the link value that is written to R7 on BL/BLX.
// The control FSM owns all sequencing. This block only reacts to its strobes.
module pc_addr_unit #(
    parameter int PC_W   = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_pc,
    input  logic              reset_pc,
    input  logic              load_bpc,
    input  logic              load_addr,
    input  logic              addr_sel,
    input  logic [2:0]        opcode,
    input  logic [1:0]        op,
    input  logic [2:0]        cond,
    input  logic [DATA_W-1:0] sximm8,
    input  logic [DATA_W-1:0] reg_target,
    input  logic [DATA_W-1:0] datapath_out,
    input  logic              status_z,
    input  logic              status_n,
    input  logic              status_v,
    output logic [PC_W-1:0]   mem_addr,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] link_pc,
    output logic              branch_taken
);

    localparam logic [2:0] OPC_BCOND = 3'b001;
    localparam logic [2:0] OPC_BREG  = 3'b010;
    localparam logic [1:0] OP_BL     = 2'b11;

    logic [PC_W-1:0] data_addr;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc_next;
    logic            taken;
    logic            branch_fire;

    // The PC and address paths only use the low PC_W bits of the wide inputs.
    logic unused_upper_bits;
    assign unused_upper_bits = ^{sximm8[DATA_W-1:PC_W],
                                 reg_target[DATA_W-1:PC_W],
                                 datapath_out[DATA_W-1:PC_W]};

    assign mem_addr = addr_sel ? pc : data_addr;
    assign link_pc  = {{(DATA_W-PC_W){1'b0}}, pc};

    // Branch condition evaluation from opcode/cond and the status flags
    always_comb begin
        taken = 1'b0;
        if (opcode == OPC_BCOND) begin
            unique case (cond)
                3'b000:  taken = 1'b1;
                3'b001:  taken = status_z;
                3'b010:  taken = ~status_z;
                3'b011:  taken = status_n ^ status_v;
                3'b100:  taken = (status_n ^ status_v) | status_z;
                default: taken = 1'b0;
            endcase
        end else if (opcode == OPC_BREG) begin
            taken = 1'b1;
        end
    end

    // Target select: BX/BLX jump to a register, everything else is PC-relative (mod 2^PC_W)
    always_comb begin
        target = pc + sximm8[PC_W-1:0];
        if (opcode == OPC_BREG && op != OP_BL) begin
            target = reg_target[PC_W-1:0];
        end
    end

    // Next-PC priority: reset_pc, then branch, then increment. Nothing changes without load_pc
    always_comb begin
        pc_next     = pc;
        branch_fire = 1'b0;
        if (load_pc) begin
            if (reset_pc) begin
                pc_next = '0;
            end else if (load_bpc) begin
                if (taken) begin
                    pc_next     = target;
                    branch_fire = 1'b1;
                end
            end else begin
                pc_next = pc + 1'b1;
            end
        end
    end

    // PC and branch-taken pulse registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc           <= '0;
            branch_taken <= 1'b0;
        end else begin
            pc           <= pc_next;
            branch_taken <= branch_fire;
        end
    end

    // Data-address register, loaded independently of the PC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_addr <= '0;
        end else if (load_addr) begin
            data_addr <= datapath_out[PC_W-1:0];
        end
    end

endmodule

// File: tb/tb_pc_addr_unit.sv
// Directed bench for pc_addr_unit. The expected values are worked out by hand from the block behaviour.
module tb_pc_addr_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_pc, reset_pc, load_bpc, load_addr, addr_sel;
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  cond;
    logic [15:0] sximm8, reg_target, datapath_out;
    logic        status_z, status_n, status_v;
    logic [8:0]  mem_addr, pc;
    logic [15:0] link_pc;
    logic        branch_taken;

    int vectors    = 0;
    int miscompares = 0;

    pc_addr_unit #(.PC_W(9), .DATA_W(16)) dut (
        .clk(clk), .reset(reset),
        .load_pc(load_pc), .reset_pc(reset_pc), .load_bpc(load_bpc),
        .load_addr(load_addr), .addr_sel(addr_sel),
        .opcode(opcode), .op(op), .cond(cond),
        .sximm8(sximm8), .reg_target(reg_target), .datapath_out(datapath_out),
        .status_z(status_z), .status_n(status_n), .status_v(status_v),
        .mem_addr(mem_addr), .pc(pc), .link_pc(link_pc),
        .branch_taken(branch_taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        load_bpc  = 1'b0;
        load_addr = 1'b0;
    endtask

    // Load an arbitrary PC via BX, then drop the strobes
    task automatic set_pc(input logic [8:0] v);
        opcode     = 3'b010;
        op         = 2'b00;
        reg_target = {7'b0, v};
        load_pc    = 1'b1;
        load_bpc   = 1'b1;
        tick();
        idle();
    endtask

    task automatic branch(input logic [2:0] opc, input logic [2:0] cnd, input logic [15:0] off,
                          input logic n, input logic v, input logic z);
        opcode   = opc;
        cond     = cnd;
        op       = 2'b00;
        sximm8   = off;
        status_n = n;
        status_v = v;
        status_z = z;
        load_pc  = 1'b1;
        load_bpc = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        reset = 1'b0;
        idle();
        addr_sel = 1'b1;
        opcode = 3'b000; op = 2'b00; cond = 3'b000;
        sximm8 = '0; reg_target = '0; datapath_out = '0;
        status_z = 1'b0; status_n = 1'b0; status_v = 1'b0;
        #12;
        check("rst_pc", pc, 0);
        check("rst_bt", branch_taken, 0);
        check("rst_mem", mem_addr, 0);
        @(negedge clk);
        reset = 1'b1;

        // sequential fetch
        load_pc = 1'b1;
        tick(); check("inc1", pc, 1);
        tick(); check("inc2", pc, 2);
        tick(); check("inc3", pc, 3); check("inc3_mem", mem_addr, 3);
        idle();
        tick(); check("hold", pc, 3);
        // async reset mid-cycle
        #2 reset = 1'b0;
        #1 check("async_rst", pc, 0);
        @(negedge clk);
        reset = 1'b1;

        // BEQ taken / not taken
        set_pc(9'd5);
        check("setpc5", pc, 5);
        branch(3'b001, 3'b001, 16'hFFFD, 1'b0, 1'b0, 1'b1);
        check("beq_t", pc, 2);
        check("beq_t_bt", branch_taken, 1);
        tick();
        check("beq_bt_clr", branch_taken, 0);
        check("beq_hold", pc, 2);
        set_pc(9'd5);
        branch(3'b001, 3'b001, 16'hFFFD, 1'b0, 1'b0, 1'b0);
        check("beq_nt", pc, 5);
        check("beq_nt_bt", branch_taken, 0);

        // BLT / BLE matrix
        set_pc(9'd10);
        branch(3'b001, 3'b011, 16'd4, 1'b1, 1'b0, 1'b0);
        check("blt_t", pc, 14);
        set_pc(9'd10);
        branch(3'b001, 3'b100, 16'd4, 1'b1, 1'b1, 1'b0);
        check("ble_nt", pc, 10);
        set_pc(9'd10);
        branch(3'b001, 3'b100, 16'd4, 1'b0, 1'b0, 1'b1);
        check("ble_t", pc, 14);
        set_pc(9'd10);
        branch(3'b001, 3'b101, 16'd4, 1'b1, 1'b0, 1'b1);
        check("c101_nt", pc, 10);
        check("c101_bt", branch_taken, 0);
        set_pc(9'd10);
        branch(3'b011, 3'b000, 16'd4, 1'b0, 1'b0, 1'b0);
        check("opc011_nt", pc, 10);

        // BX and BL
        set_pc(9'd20);
        set_pc(9'h107);
        check("bx", pc, 9'h107);
        check("bx_bt", branch_taken, 1);
        set_pc(9'd20);
        check("link", link_pc, 16'd20);
        opcode = 3'b010; op = 2'b11; sximm8 = 16'h0003; reg_target = 16'h0055;
        load_pc = 1'b1; load_bpc = 1'b1;
        tick(); idle();
        check("bl", pc, 23);
        check("link23", link_pc, 16'd23);

        // strobes without load_pc do nothing
        reset_pc = 1'b1; load_bpc = 1'b1; opcode = 3'b010; op = 2'b00;
        tick(); idle();
        check("no_load", pc, 23);

        // wrap cases
        set_pc(9'h1FF);
        load_pc = 1'b1;
        tick(); idle();
        check("wrap_inc", pc, 0);
        branch(3'b001, 3'b000, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        check("wrap_neg", pc, 9'h1FF);

        // data address with a simultaneous PC increment
        datapath_out = 16'hF123;
        load_addr = 1'b1; load_pc = 1'b1;
        tick(); idle();
        addr_sel = 1'b0;
        #1 check("daddr", mem_addr, 9'h123);
        check("daddr_pc", pc, 0);
        datapath_out = 16'h0077;
        tick();
        check("daddr_hold", mem_addr, 9'h123);
        addr_sel = 1'b1;
        #1 check("mem_pc", mem_addr, 0);

        // reset_pc beats a taken branch
        set_pc(9'd40);
        opcode = 3'b010; op = 2'b00; reg_target = 16'd99;
        load_pc = 1'b1; load_bpc = 1'b1; reset_pc = 1'b1;
        tick(); idle();
        check("rstpc", pc, 0);
        check("rstpc_bt", branch_taken, 0);

        // async reset clears the data address
        #2 reset = 1'b0;
        addr_sel = 1'b0;
        #1 check("rst_daddr", mem_addr, 0);
        reset = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_addr_unit.md
Name: pc_addr_unit

Overview:
- Program counter and memory address stage; consumes the control FSM's PC and address strobes: load_pc, reset_pc, load_bpc, load_addr, addr_sel.
- Holds PC and the data-address register, evaluates branch conditions from status flags, and computes branch targets (PC-relative or register-indirect).
- Drives the shared memory address bus and supplies the link value written to R7 on BL/BLX.

Parameters:
PC_W, 9, width of PC, data-address register and mem_addr
DATA_W, 16, datapath word width (sximm8, reg_target, datapath_out, link_pc)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
load_pc  input  1  update PC this cycle
reset_pc  input  1  force next PC to 0 (qualified by load_pc)
load_bpc  input  1  branch cycle: next PC is the branch target when taken
load_addr  input  1  capture datapath_out into the data-address register
addr_sel  input  1  1: mem_addr=PC, 0: mem_addr=data address
opcode  input  3  current instruction opcode
op  input  2  current instruction op field
cond  input  3  branch condition field
sximm8  input  DATA_W  sign-extended 8-bit offset
reg_target  input  DATA_W  register value for BX/BLX
datapath_out  input  DATA_W  datapath C output (load/store address)
status_z  input  1  zero flag
status_n  input  1  negative flag
status_v  input  1  overflow flag
mem_addr  output  PC_W  memory address bus
pc  output  PC_W  current PC
link_pc  output  DATA_W  zero-extended PC, used for R7 write on BL/BLX
branch_taken  output  1  registered one-cycle pulse after a taken branch

Behaviour:
- Reset (reset=0, asynchronous): pc=0, data_addr=0, branch_taken=0. Effective immediately, including mid-instruction.
- Combinational outputs:
  - mem_addr = addr_sel ? pc : data_addr.
  - link_pc = {0, pc}.
- PC update, on the rising edge, in priority order:
  1. load_pc & reset_pc: pc<=0. reset_pc wins over load_bpc.
  2. load_pc & load_bpc: pc<=target if taken, else pc holds. PC was already incremented at fetch, so a not-taken branch falls through.
  3. load_pc only: pc<=pc+1.
  4. load_pc=0: pc holds. reset_pc or load_bpc without load_pc has no effect.
- Taken evaluation (combinational):
  - opcode 001, by cond:
    - 000 always taken.
    - 001 taken when Z=1.
    - 010 taken when Z=0.
    - 011 taken when N!=V.
    - 100 taken when (N!=V)|Z.
    - 101/110/111 never taken.
  - opcode 010: always taken.
  - Any other opcode: not taken.
- Target:
  - opcode 001, or opcode 010 with op=11 (BL): pc + sximm8[PC_W-1:0].
  - opcode 010 with op!=11 (BX, BLX): reg_target[PC_W-1:0].
- Arithmetic is modulo 2^PC_W.
  - pc=2^PC_W-1 increments to 0.
  - Negative offsets wrap: pc=0, sximm8=-1 gives target=2^PC_W-1.
  - Upper bits of reg_target and datapath_out are discarded.
- Data address: load_addr=1 gives data_addr<=datapath_out[PC_W-1:0] on the edge; otherwise it holds. It is independent of PC updates, so simultaneous load_addr and load_pc both take effect.
- branch_taken: registered; equals 1 for exactly the cycle after an edge where load_pc & load_bpc & taken & !reset_pc; else 0.
- Flags, opcode, op, cond, sximm8 and reg_target are sampled only in the load_bpc cycle; they may change freely at other times.
- No internal state machine beyond the registers. All sequencing is owned by the control FSM; this block never stalls.

Test Plan:
1. Release reset, then pulse load_pc three times with addr_sel=1 -> pc and mem_addr step 0,1,2,3. Assert reset=0 mid-run -> pc=0 immediately, with no clock edge needed.
2. pc=5; BEQ (opcode 001, cond 001, sximm8=16'hFFFD), load_pc+load_bpc:
   - Z=1 -> pc=2, branch_taken=1 for one cycle.
   - Repeat with Z=0 -> pc stays 5, branch_taken=0.
3. BLT/BLE flag matrix at pc=10, sximm8=4:
   - N=1,V=0 -> 14.
   - N=1,V=1,Z=0 on BLE -> 10.
   - N=0,V=0,Z=1 on BLE -> 14.
   - cond 101 -> 10.
4. BX at pc=20 (opcode 010, op 00, reg_target=16'h0107) -> pc=9'h107. BL at pc=20, sximm8=16'h0003 -> pc=23; link_pc reads 16'd20 before the branch edge.
5. Wrap: pc=9'h1FF, load_pc -> 0. Separately, pc=0, B with sximm8=16'hFFFF -> pc=9'h1FF.
6. load_addr with datapath_out=16'hF123 and addr_sel=0 -> mem_addr=9'h123 next cycle. load_pc+reset_pc+load_bpc together -> pc=0 and branch_taken=0.
